// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: frame-granular round-robin arbiter feeding a single UDP
// transmit path. One requester owns the path from header acceptance through
// its payload tlast, so headers and payload bytes from different requesters
// can never interleave. The header is registered; the payload is a
// zero-latency combinational pass-through of the owning port.
module udp_tx_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ID_W      = $clog2(NUM_PORTS)
) (
   input  logic                   clk,
   input  logic                   reset,
   // per-requester header
   input  logic [NUM_PORTS-1:0]    s_hdr_valid,
   output logic [NUM_PORTS-1:0]    s_hdr_ready,
   input  logic [NUM_PORTS*32-1:0] s_hdr_dest_ip,
   input  logic [NUM_PORTS*16-1:0] s_hdr_source_port,
   input  logic [NUM_PORTS*16-1:0] s_hdr_dest_port,
   input  logic [NUM_PORTS*16-1:0] s_hdr_length,
   // per-requester payload
   input  logic [NUM_PORTS*8-1:0]  s_tdata,
   input  logic [NUM_PORTS-1:0]    s_tvalid,
   input  logic [NUM_PORTS-1:0]    s_tlast,
   input  logic [NUM_PORTS-1:0]    s_tuser,
   output logic [NUM_PORTS-1:0]    s_tready,
   // header to UDP stack
   output logic                   m_hdr_valid,
   input  logic                   m_hdr_ready,
   output logic [31:0]            m_hdr_dest_ip,
   output logic [15:0]            m_hdr_source_port,
   output logic [15:0]            m_hdr_dest_port,
   output logic [15:0]            m_hdr_length,
   // payload to UDP stack
   output logic [7:0]             m_tdata,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   output logic                   m_tuser,
   input  logic                   m_tready,
   // status
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD
   } state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [31:0]     dest_ip_q, dest_ip_d;
   logic [15:0]     src_port_q, src_port_d;
   logic [15:0]     dst_port_q, dst_port_d;
   logic [15:0]     length_q, length_d;

   logic [ID_W-1:0] winner;
   logic            any_req;

   // Round-robin search: start one past the last owner, first requester wins.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] cand;
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(last_grant_q) + 1 + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         cand = ID_W'(idx);
         if (!any_req && s_hdr_valid[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   // Next-state, header capture and payload steering for the owning port.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      dest_ip_d    = dest_ip_q;
      src_port_d   = src_port_q;
      dst_port_d   = dst_port_q;
      length_d     = length_q;
      s_hdr_ready  = '0;
      s_tready     = '0;
      m_tdata      = '0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      m_tuser      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               s_hdr_ready[winner] = 1'b1;
               dest_ip_d  = s_hdr_dest_ip[32*winner +: 32];
               src_port_d = s_hdr_source_port[16*winner +: 16];
               dst_port_d = s_hdr_dest_port[16*winner +: 16];
               length_d   = s_hdr_length[16*winner +: 16];
               grant_d    = winner;
               state_d    = ST_HDR;
            end
         end
         ST_HDR: begin
            if (m_hdr_ready) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            m_tdata            = s_tdata[8*grant_q +: 8];
            m_tvalid           = s_tvalid[grant_q];
            m_tlast            = s_tlast[grant_q];
            m_tuser            = s_tuser[grant_q];
            s_tready[grant_q]  = m_tready;
            if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and header registers; reset gives port 0 first priority.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_PORTS - 1);
         dest_ip_q    <= '0;
         src_port_q   <= '0;
         dst_port_q   <= '0;
         length_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         dest_ip_q    <= dest_ip_d;
         src_port_q   <= src_port_d;
         dst_port_q   <= dst_port_d;
         length_q     <= length_d;
      end
   end

   assign m_hdr_valid       = (state_q == ST_HDR);
   assign busy              = (state_q != ST_IDLE);
   assign grant_id          = grant_q;
   assign m_hdr_dest_ip     = dest_ip_q;
   assign m_hdr_source_port = src_port_q;
   assign m_hdr_dest_port   = dst_port_q;
   assign m_hdr_length      = length_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench for udp_tx_arbiter. Drivers push the
// expected header and beats of each frame as they start it; a negedge monitor
// pops and compares whatever the arbiter forwards.
module tb_udp_tx_arbiter;

   localparam int NP  = 4;
   localparam int IDW = 2;
   localparam int TMO = 2000;

   typedef struct {
      int          port;
      logic [31:0] ip;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [15:0] len;
   } hdr_t;

   typedef struct {
      int         port;
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic [NP-1:0]    s_hdr_valid, s_hdr_ready;
   logic [NP*32-1:0] s_hdr_dest_ip;
   logic [NP*16-1:0] s_hdr_source_port, s_hdr_dest_port, s_hdr_length;
   logic [NP*8-1:0]  s_tdata;
   logic [NP-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
   logic             m_hdr_valid;
   logic             m_hdr_ready = 1'b1;
   logic [31:0]      m_hdr_dest_ip;
   logic [15:0]      m_hdr_source_port, m_hdr_dest_port, m_hdr_length;
   logic [7:0]       m_tdata;
   logic             m_tvalid, m_tlast, m_tuser;
   logic             m_tready = 1'b1;
   logic [IDW-1:0]   grant_id;
   logic             busy;

   // per-port source-side drive
   logic        hv [NP];
   logic [31:0] hip [NP];
   logic [15:0] hsp [NP], hdp [NP], hlen [NP];
   logic [7:0]  td [NP];
   logic        tv [NP], tl [NP], tu [NP];

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign s_hdr_valid[g]               = hv[g];
      assign s_hdr_dest_ip[32*g +: 32]    = hip[g];
      assign s_hdr_source_port[16*g +: 16] = hsp[g];
      assign s_hdr_dest_port[16*g +: 16]  = hdp[g];
      assign s_hdr_length[16*g +: 16]     = hlen[g];
      assign s_tdata[8*g +: 8]            = td[g];
      assign s_tvalid[g]                  = tv[g];
      assign s_tlast[g]                   = tl[g];
      assign s_tuser[g]                   = tu[g];
   end

   udp_tx_arbiter #(.NUM_PORTS(NP), .ID_W(IDW)) dut (
      .clk               (clk),
      .reset             (reset),
      .s_hdr_valid       (s_hdr_valid),
      .s_hdr_ready       (s_hdr_ready),
      .s_hdr_dest_ip     (s_hdr_dest_ip),
      .s_hdr_source_port (s_hdr_source_port),
      .s_hdr_dest_port   (s_hdr_dest_port),
      .s_hdr_length      (s_hdr_length),
      .s_tdata           (s_tdata),
      .s_tvalid          (s_tvalid),
      .s_tlast           (s_tlast),
      .s_tuser           (s_tuser),
      .s_tready          (s_tready),
      .m_hdr_valid       (m_hdr_valid),
      .m_hdr_ready       (m_hdr_ready),
      .m_hdr_dest_ip     (m_hdr_dest_ip),
      .m_hdr_source_port (m_hdr_source_port),
      .m_hdr_dest_port   (m_hdr_dest_port),
      .m_hdr_length      (m_hdr_length),
      .m_tdata           (m_tdata),
      .m_tvalid          (m_tvalid),
      .m_tlast           (m_tlast),
      .m_tuser           (m_tuser),
      .m_tready          (m_tready),
      .grant_id          (grant_id),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   int    vectors = 0;
   int    miscompares = 0;
   hdr_t  exp_hdr_q [$];
   beat_t exp_beat_q [$];
   int    grant_log [$];
   int    hdr_count [NP];
   int    seq_cnt [NP];
   int    mon_owner = -1;
   int    mon_p;
   int    mon_idx;

   // Monitor: every forwarded header and beat must match the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         mon_owner = -1;
      end else begin
         if (m_hdr_valid && m_hdr_ready) begin
            mon_p   = int'(m_hdr_source_port[15:12]);
            mon_idx = -1;
            for (int i = 0; i < exp_hdr_q.size(); i++)
               if (mon_idx < 0 && exp_hdr_q[i].port == mon_p) mon_idx = i;
            vectors++;
            if (mon_idx < 0) begin
               miscompares++;
               $display("FAIL hdr_unexpected: got sp=%h, required no header from port %0d", m_hdr_source_port, mon_p);
            end else begin
               if (m_hdr_dest_ip !== exp_hdr_q[mon_idx].ip || m_hdr_source_port !== exp_hdr_q[mon_idx].sp ||
                   m_hdr_dest_port !== exp_hdr_q[mon_idx].dp || m_hdr_length !== exp_hdr_q[mon_idx].len) begin
                  miscompares++;
                  $display("FAIL hdr_fields: got ip=%h sp=%h dp=%h len=%h, required ip=%h sp=%h dp=%h len=%h",
                           m_hdr_dest_ip, m_hdr_source_port, m_hdr_dest_port, m_hdr_length,
                           exp_hdr_q[mon_idx].ip, exp_hdr_q[mon_idx].sp, exp_hdr_q[mon_idx].dp, exp_hdr_q[mon_idx].len);
               end
               exp_hdr_q.delete(mon_idx);
            end
            vectors++;
            if (int'(grant_id) !== mon_p) begin
               miscompares++;
               $display("FAIL hdr_grant_id: got %0d, required %0d", grant_id, mon_p);
            end
            grant_log.push_back(mon_p);
            hdr_count[mon_p]++;
            mon_owner = mon_p;
         end
         if (m_tvalid && m_tready) begin
            vectors++;
            mon_idx = -1;
            for (int i = 0; i < exp_beat_q.size(); i++)
               if (mon_idx < 0 && exp_beat_q[i].port == mon_owner) mon_idx = i;
            if (mon_owner < 0 || mon_idx < 0) begin
               miscompares++;
               $display("FAIL beat_unexpected: got data=%h last=%b with owner %0d, required no beat", m_tdata, m_tlast, mon_owner);
            end else begin
               if (m_tdata !== exp_beat_q[mon_idx].data || m_tlast !== exp_beat_q[mon_idx].last ||
                   m_tuser !== exp_beat_q[mon_idx].user) begin
                  miscompares++;
                  $display("FAIL beat port %0d: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                           mon_owner, m_tdata, m_tlast, m_tuser, exp_beat_q[mon_idx].data,
                           exp_beat_q[mon_idx].last, exp_beat_q[mon_idx].user);
               end
               if (exp_beat_q[mon_idx].last) mon_owner = -1;
               exp_beat_q.delete(mon_idx);
            end
         end
      end
   end

   // Whole-run watchdog.
   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic apply_reset();
      reset = 1'b1;
      for (int p = 0; p < NP; p++) begin
         hv[p] = 1'b0; hip[p] = '0; hsp[p] = '0; hdp[p] = '0; hlen[p] = '0;
         tv[p] = 1'b0; td[p] = '0; tl[p] = 1'b0; tu[p] = 1'b0;
      end
      m_hdr_ready = 1'b1;
      m_tready    = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Drive one frame from port p; expected header and beats are pushed first.
   task automatic send_frame(input int p, input int nbytes, input int gap_pct, input int fixed_byte);
      hdr_t  h;
      beat_t bt;
      bit    ok;
      int    seq;
      seq = seq_cnt[p];
      seq_cnt[p]++;
      h.port = p;
      h.ip   = {8'd10, 8'(p), 16'(seq)};
      h.sp   = {4'(p), 12'(seq)};
      h.dp   = 16'(1000 + p);
      h.len  = 16'(8 + nbytes);
      exp_hdr_q.push_back(h);
      @(posedge clk);
      #1;
      hv[p] = 1'b1; hip[p] = h.ip; hsp[p] = h.sp; hdp[p] = h.dp; hlen[p] = h.len;
      ok = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         @(negedge clk);
         if (s_hdr_ready[p]) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1 hv[p] = 1'b0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL hdr_timeout port %0d: got no s_hdr_ready in %0d cycles, required a grant", p, TMO);
         return;
      end
      for (int b = 0; b < nbytes; b++) begin
         bt.port = p;
         bt.data = (fixed_byte >= 0) ? 8'(fixed_byte) : 8'($urandom);
         bt.last = (b == nbytes - 1);
         bt.user = bt.last ? 1'($urandom_range(0, 1)) : 1'b0;
         exp_beat_q.push_back(bt);
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            tv[p] = 1'b0;
            @(posedge clk);
            #1;
         end
         tv[p] = 1'b1; td[p] = bt.data; tl[p] = bt.last; tu[p] = bt.user;
         ok = 1'b0;
         for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (s_tready[p]) begin ok = 1'b1; break; end
         end
         @(posedge clk);
         #1;
         if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL beat_timeout port %0d: got no s_tready in %0d cycles, required acceptance", p, TMO);
            tv[p] = 1'b0;
            return;
         end
      end
      tv[p] = 1'b0; tl[p] = 1'b0; tu[p] = 1'b0;
   endtask

   task automatic check_log(input string name, input int exp_order [$]);
      vectors++;
      if (grant_log.size() != exp_order.size()) begin
         miscompares++;
         $display("FAIL %s: got %0d grants, required %0d", name, grant_log.size(), exp_order.size());
      end else begin
         for (int i = 0; i < exp_order.size(); i++) begin
            if (grant_log[i] != exp_order[i]) begin
               miscompares++;
               $display("FAIL %s: grant %0d got port %0d, required port %0d", name, i, grant_log[i], exp_order[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      vectors++;
      if ({m_hdr_valid, busy, m_tvalid} !== 3'b000 || grant_id !== '0 || s_hdr_ready !== '0 || s_tready !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got hv=%b busy=%b tv=%b gid=%0d hrdy=%b trdy=%b, required all 0",
                  m_hdr_valid, busy, m_tvalid, grant_id, s_hdr_ready, s_tready);
      end
      vectors++;
      if (m_hdr_dest_ip !== '0 || m_hdr_source_port !== '0 || m_hdr_dest_port !== '0 || m_hdr_length !== '0) begin
         miscompares++;
         $display("FAIL reset_fields: got ip=%h sp=%h dp=%h len=%h, required 0", m_hdr_dest_ip,
                  m_hdr_source_port, m_hdr_dest_port, m_hdr_length);
      end
   endtask

   task automatic test_single();
      hdr_t  h;
      beat_t bt;
      h = '{port: 2, ip: 32'hC0A8_0002, sp: {4'd2, 12'h0AB}, dp: 16'd5000, len: 16'd12};
      exp_hdr_q.push_back(h);
      for (int b = 0; b < 4; b++) begin
         bt = '{port: 2, data: 8'hA0 + 8'(b), last: (b == 3), user: 1'b0};
         exp_beat_q.push_back(bt);
      end
      @(posedge clk);
      #1;
      hv[2] = 1'b1; hip[2] = h.ip; hsp[2] = h.sp; hdp[2] = h.dp; hlen[2] = h.len;
      @(negedge clk);
      vectors++;
      if (s_hdr_ready !== 4'b0100 || m_hdr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_accept: got hrdy=%b hv=%b, required hrdy=0100 hv=0", s_hdr_ready, m_hdr_valid);
      end
      @(posedge clk);
      #1 hv[2] = 1'b0;
      @(negedge clk);
      vectors++;
      if (m_hdr_valid !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b1 || m_hdr_dest_port !== 16'd5000 ||
          m_hdr_length !== 16'd12) begin
         miscompares++;
         $display("FAIL single_hdr_t1: got hv=%b gid=%0d busy=%b dp=%0d len=%0d, required hv=1 gid=2 busy=1 dp=5000 len=12",
                  m_hdr_valid, grant_id, busy, m_hdr_dest_port, m_hdr_length);
      end
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
         #1;
         tv[2] = 1'b1; td[2] = 8'hA0 + 8'(b); tl[2] = (b == 3); tu[2] = 1'b0;
         @(negedge clk);
         vectors++;
         if (m_tvalid !== 1'b1 || m_tdata !== 8'hA0 + 8'(b) || s_tready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_beat%0d: got tv=%b data=%h trdy=%b, required tv=1 data=%h trdy=0100",
                     b, m_tvalid, m_tdata, s_tready, 8'hA0 + 8'(b));
         end
         @(posedge clk);
      end
      #1;
      tv[2] = 1'b0; tl[2] = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_busy_p1: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      grant_log.delete();
      fork
         begin
            send_frame(0, 3, 0, -1);
            send_frame(0, 3, 0, -1);
         end
         send_frame(1, 3, 0, -1);
         send_frame(2, 3, 0, -1);
         send_frame(3, 3, 0, -1);
      join
      repeat (2) @(posedge clk);
      check_log("simultaneous_order", '{0, 1, 2, 3, 0});
   endtask

   task automatic test_holdoff();
      int h3_start;
      h3_start = hdr_count[3];
      grant_log.delete();
      @(posedge clk);
      #1;
      tv[3] = 1'b1; td[3] = 8'h55; tl[3] = 1'b1; tu[3] = 1'b0;
      fork
         send_frame(1, 4, 0, -1);
         begin
            repeat (2) @(posedge clk);
            send_frame(3, 1, 0, 8'h55);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 300; c++) begin
               @(negedge clk);
               if (hdr_count[3] > h3_start) begin seen = 1'b1; break; end
               vectors++;
               if (s_tready[3] !== 1'b0) begin
                  miscompares++;
                  $display("FAIL holdoff_tready3: got 1 at cycle %0d, required 0", c);
               end
            end
            if (!seen) begin
               vectors++; miscompares++;
               $display("FAIL holdoff_timeout: got no port 3 header, required one");
            end
         end
      join
      repeat (2) @(posedge clk);
      check_log("holdoff_order", '{1, 3});
   endtask

   task automatic test_hdr_hold();
      hdr_t  h;
      beat_t bt;
      h  = '{port: 0, ip: 32'h0A0B_0C0D, sp: {4'd0, 12'h777}, dp: 16'h1234, len: 16'd9};
      bt = '{port: 0, data: 8'h77, last: 1'b1, user: 1'b1};
      exp_hdr_q.push_back(h);
      exp_beat_q.push_back(bt);
      m_hdr_ready = 1'b0;
      m_tready    = 1'b1;
      @(posedge clk);
      #1;
      hv[0] = 1'b1; hip[0] = h.ip; hsp[0] = h.sp; hdp[0] = h.dp; hlen[0] = h.len;
      @(negedge clk);
      @(posedge clk);
      #1;
      hv[0] = 1'b0; hip[0] = '1; hsp[0] = '1; hdp[0] = '1; hlen[0] = '1;
      tv[0] = 1'b1; td[0] = 8'h77; tl[0] = 1'b1; tu[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vectors++;
         if (m_hdr_valid !== 1'b1 || m_hdr_dest_ip !== h.ip || m_hdr_source_port !== h.sp ||
             m_hdr_dest_port !== h.dp || m_hdr_length !== h.len) begin
            miscompares++;
            $display("FAIL hold_fields c%0d: got hv=%b ip=%h sp=%h dp=%h len=%h, required hv=1 ip=%h sp=%h dp=%h len=%h",
                     c, m_hdr_valid, m_hdr_dest_ip, m_hdr_source_port, m_hdr_dest_port, m_hdr_length,
                     h.ip, h.sp, h.dp, h.len);
         end
         vectors++;
         if (s_tready !== '0 || m_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_payload c%0d: got trdy=%b tv=%b, required 0", c, s_tready, m_tvalid);
         end
         @(posedge clk);
         #1;
      end
      m_hdr_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (s_tready !== 4'b0001 || m_tvalid !== 1'b1 || m_tdata !== 8'h77) begin
         miscompares++;
         $display("FAIL hold_release: got trdy=%b tv=%b data=%h, required trdy=0001 tv=1 data=77",
                  s_tready, m_tvalid, m_tdata);
      end
      @(posedge clk);
      #1;
      tv[0] = 1'b0; tl[0] = 1'b0; tu[0] = 1'b0;
   endtask

   task automatic test_random();
      bit bp_done;
      bp_done = 1'b0;
      fork
         begin
            fork
               for (int k = 0; k < 50; k++) send_frame(0, $urandom_range(1, 8), 30, -1);
               for (int k = 0; k < 50; k++) send_frame(1, $urandom_range(1, 8), 30, -1);
               for (int k = 0; k < 50; k++) send_frame(2, $urandom_range(1, 8), 30, -1);
               for (int k = 0; k < 50; k++) send_frame(3, $urandom_range(1, 8), 30, -1);
            join
            bp_done = 1'b1;
         end
         while (!bp_done) begin
            @(posedge clk);
            #1;
            m_tready    = 1'($urandom_range(0, 1));
            m_hdr_ready = 1'($urandom_range(0, 1));
         end
      join
      m_tready    = 1'b1;
      m_hdr_ready = 1'b1;
      repeat (3) @(posedge clk);
      vectors++;
      if (exp_hdr_q.size() != 0 || exp_beat_q.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL random_drain: got %0d hdrs %0d beats pending busy=%b, required 0 0 0",
                  exp_hdr_q.size(), exp_beat_q.size(), busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      hdr_t  h;
      beat_t bt;
      // port 1 finishes last, so without reinitialisation port 2 would win next
      send_frame(1, 2, 0, -1);
      h = '{port: 2, ip: 32'h0A02_0FFF, sp: {4'd2, 12'hFFF}, dp: 16'd2002, len: 16'd14};
      exp_hdr_q.push_back(h);
      for (int b = 0; b < 2; b++) begin
         bt = '{port: 2, data: 8'h10 + 8'(b), last: 1'b0, user: 1'b0};
         exp_beat_q.push_back(bt);
      end
      @(posedge clk);
      #1;
      hv[2] = 1'b1; hip[2] = h.ip; hsp[2] = h.sp; hdp[2] = h.dp; hlen[2] = h.len;
      @(posedge clk);
      #1 hv[2] = 1'b0;
      @(posedge clk);
      for (int b = 0; b < 3; b++) begin
         #1;
         tv[2] = 1'b1; td[2] = 8'h10 + 8'(b); tl[2] = 1'b0;
         if (b == 2) reset = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      vectors++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || s_tready !== '0) begin
         miscompares++;
         $display("FAIL midreset_state: got tv=%b busy=%b gid=%0d trdy=%b, required tv=0 busy=0 gid=0 trdy=0",
                  m_tvalid, busy, grant_id, s_tready);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tv[2] = 1'b0;
      grant_log.delete();
      fork
         send_frame(0, 2, 0, -1);
         send_frame(2, 2, 0, -1);
      join
      repeat (2) @(posedge clk);
      check_log("midreset_order", '{0, 2});
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         hdr_count[p] = 0;
         seq_cnt[p]   = 0;
      end
      test_reset();
      test_single();
      test_simultaneous();
      test_holdoff();
      test_hdr_hold();
      test_random();
      test_reset_mid_frame();
      vectors++;
      if (exp_hdr_q.size() != 0 || exp_beat_q.size() != 0) begin
         miscompares++;
         $display("FAIL final_drain: got %0d hdrs %0d beats pending, required 0 0", exp_hdr_q.size(), exp_beat_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
